// File: rtl/wb_regfile_scoreboard.sv
// Write-back stage of the 19-bit pipeline: result select, register file commit,
// bypassed decode read ports, per-register pending-write scoreboard with stall,
// retire counter and sticky scoreboard-error flag.
//
// Handshake: decode's issue is accepted in a cycle when issue_valid && issue_we
// && !stall; there is no ready back to the W stage (a RegWriteW cycle always
// commits). stall depends only on read addresses, ra_use, W-stage inputs and
// state, never on issue_*, so it can gate the issue accept in the same cycle.
module wb_regfile_scoreboard #(
    parameter int DW = 19,
    parameter int AW = 2,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegWriteW,
    input  logic          memtoregW,
    input  logic [DW-1:0] RdOutW,
    input  logic [DW-1:0] AluOutW,
    input  logic [AW-1:0] r1W_addr,
    input  logic          issue_valid,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    input  logic [2:0]    ra_use,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] rd3,
    output logic          stall,
    output logic [CW-1:0] retire_count,
    output logic          sb_err
);

    localparam int NR = 1 << AW;

    logic [DW-1:0] regs    [NR];
    logic [1:0]    pend    [NR];
    logic [1:0]    pend_nx [NR];
    logic [AW-1:0] ra_a    [3];
    logic [DW-1:0] rd_a    [3];
    logic [DW-1:0] wb_data;
    logic          issue_acc;
    logic          err_hit;

    assign wb_data   = memtoregW ? RdOutW : AluOutW;
    assign issue_acc = issue_valid && issue_we && !stall;
    assign rd1       = rd_a[0];
    assign rd2       = rd_a[1];
    assign rd3       = rd_a[2];

    // Read ports with write-through bypass, and hazard detection for used ports.
    // A port whose only outstanding write is committing right now is not a hazard.
    always_comb begin
        ra_a[0] = ra1;
        ra_a[1] = ra2;
        ra_a[2] = ra3;
        stall   = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (RegWriteW && (r1W_addr == ra_a[p])) begin
                rd_a[p] = wb_data;
            end else begin
                rd_a[p] = regs[ra_a[p]];
            end
            if (ra_use[p] && (pend[ra_a[p]] != 2'd0) &&
                !(RegWriteW && (r1W_addr == ra_a[p]) && (pend[ra_a[p]] == 2'd1))) begin
                stall = 1'b1;
            end
        end
    end

    // Scoreboard next state: same-register inc/dec cancel; saturate and flag errors.
    always_comb begin
        err_hit = 1'b0;
        for (int r = 0; r < NR; r++) begin
            pend_nx[r] = pend[r];
            if (issue_acc && (issue_rd == AW'(r)) &&
                !(RegWriteW && (r1W_addr == AW'(r)))) begin
                if (pend[r] == 2'd3) begin
                    err_hit = 1'b1;
                end else begin
                    pend_nx[r] = pend[r] + 2'd1;
                end
            end else if (RegWriteW && (r1W_addr == AW'(r)) &&
                         !(issue_acc && (issue_rd == AW'(r)))) begin
                if (pend[r] == 2'd0) begin
                    err_hit = 1'b1;
                end else begin
                    pend_nx[r] = pend[r] - 2'd1;
                end
            end
        end
    end

    // Register file commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NR; r++) regs[r] <= '0;
        end else if (RegWriteW) begin
            regs[r1W_addr] <= wb_data;
        end
    end

    // Scoreboard state, retire counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NR; r++) pend[r] <= 2'd0;
            retire_count <= '0;
            sb_err       <= 1'b0;
        end else begin
            for (int r = 0; r < NR; r++) pend[r] <= pend_nx[r];
            if (RegWriteW) retire_count <= retire_count + 1'b1;
            if (err_hit) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: inputs change 1 time unit after a
// rising edge, outputs are sampled 2 units later, before the next edge.
module tb_wb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteW = 1'b0;
    logic        memtoregW = 1'b0;
    logic [18:0] RdOutW = '0;
    logic [18:0] AluOutW = '0;
    logic [1:0]  r1W_addr = '0;
    logic        issue_valid = 1'b0;
    logic        issue_we = 1'b0;
    logic [1:0]  issue_rd = '0;
    logic [1:0]  ra1 = '0;
    logic [1:0]  ra2 = '0;
    logic [1:0]  ra3 = '0;
    logic [2:0]  ra_use = '0;
    logic [18:0] rd1, rd2, rd3;
    logic        stall;
    logic [15:0] retire_count;
    logic        sb_err;

    int n_vec = 0;
    int n_err = 0;

    wb_regfile_scoreboard #(.DW(19), .AW(2), .CW(16)) dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .memtoregW(memtoregW),
        .RdOutW(RdOutW), .AluOutW(AluOutW), .r1W_addr(r1W_addr),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .ra_use(ra_use),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .stall(stall),
        .retire_count(retire_count), .sb_err(sb_err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        RegWriteW = 1'b0; memtoregW = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
        ra_use = 3'b000;
    endtask

    task automatic issue(input logic [1:0] rd);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
    endtask

    task automatic test_reset();
        rst = 1'b0; RegWriteW = 1'b1; memtoregW = 1'b0; AluOutW = 19'h12345;
        r1W_addr = 2'd2; ra1 = 2'd0; ra2 = 2'd0; ra3 = 2'd0; ra_use = 3'b111;
        tick(); tick(); settle();
        n_vec++; if (rd1 !== 19'h0) begin $display("FAIL reset_rd1 got %h exp %h", rd1, 19'h0); n_err++; end
        n_vec++; if (rd3 !== 19'h0) begin $display("FAIL reset_rd3 got %h exp %h", rd3, 19'h0); n_err++; end
        n_vec++; if (retire_count !== 16'd0) begin $display("FAIL reset_retire got %0d exp 0", retire_count); n_err++; end
        n_vec++; if (sb_err !== 1'b0) begin $display("FAIL reset_sb_err got %b exp 0", sb_err); n_err++; end
        n_vec++; if (stall !== 1'b0) begin $display("FAIL reset_stall got %b exp 0", stall); n_err++; end
        // release, issue r2, then commit it
        tick(); RegWriteW = 1'b0; ra_use = 3'b000; rst = 1'b1;
        tick(); issue(2'd2);
        tick(); idle_inputs(); RegWriteW = 1'b1; r1W_addr = 2'd2; AluOutW = 19'h12345;
        tick(); idle_inputs(); ra1 = 2'd2; ra_use = 3'b001; settle();
        n_vec++; if (rd1 !== 19'h12345) begin $display("FAIL reset_first_write got %h exp %h", rd1, 19'h12345); n_err++; end
        n_vec++; if (retire_count !== 16'd1) begin $display("FAIL reset_first_retire got %0d exp 1", retire_count); n_err++; end
        n_vec++; if (stall !== 1'b0) begin $display("FAIL reset_first_stall got %b exp 0", stall); n_err++; end
        n_vec++; if (sb_err !== 1'b0) begin $display("FAIL reset_first_sb_err got %b exp 0", sb_err); n_err++; end
    endtask

    task automatic test_mux_bypass();
        tick(); idle_inputs(); issue(2'd3);
        tick(); idle_inputs(); RegWriteW = 1'b1; memtoregW = 1'b1; RdOutW = 19'h7ABCD;
        AluOutW = 19'h00001; r1W_addr = 2'd3; ra1 = 2'd3; ra2 = 2'd3; ra3 = 2'd3; ra_use = 3'b111;
        settle();
        n_vec++; if (rd1 !== 19'h7ABCD) begin $display("FAIL bypass_rd1 got %h exp %h", rd1, 19'h7ABCD); n_err++; end
        n_vec++; if (rd2 !== 19'h7ABCD) begin $display("FAIL bypass_rd2 got %h exp %h", rd2, 19'h7ABCD); n_err++; end
        n_vec++; if (rd3 !== 19'h7ABCD) begin $display("FAIL bypass_rd3 got %h exp %h", rd3, 19'h7ABCD); n_err++; end
        n_vec++; if (stall !== 1'b0) begin $display("FAIL bypass_stall got %b exp 0", stall); n_err++; end
        tick(); RegWriteW = 1'b0; memtoregW = 1'b0; settle();
        n_vec++; if (rd2 !== 19'h7ABCD) begin $display("FAIL bypass_held_rd2 got %h exp %h", rd2, 19'h7ABCD); n_err++; end
        n_vec++; if (rd1 !== 19'h7ABCD) begin $display("FAIL bypass_held_rd1 got %h exp %h", rd1, 19'h7ABCD); n_err++; end
        n_vec++; if (retire_count !== 16'd2) begin $display("FAIL bypass_retire got %0d exp 2", retire_count); n_err++; end
    endtask

    task automatic test_hazard();
        tick(); idle_inputs(); issue(2'd1);
        // stalled issue of r1 must not be accepted
        tick(); idle_inputs(); ra1 = 2'd1; ra_use = 3'b001; issue(2'd1); settle();
        n_vec++; if (stall !== 1'b1) begin $display("FAIL hazard_used got %b exp 1", stall); n_err++; end
        tick(); idle_inputs(); ra1 = 2'd1; ra_use = 3'b000; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL hazard_unused got %b exp 0", stall); n_err++; end
        tick(); ra_use = 3'b001; RegWriteW = 1'b1; r1W_addr = 2'd1; AluOutW = 19'h2A5A5; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL hazard_commit_stall got %b exp 0", stall); n_err++; end
        n_vec++; if (rd1 !== 19'h2A5A5) begin $display("FAIL hazard_commit_rd1 got %h exp %h", rd1, 19'h2A5A5); n_err++; end
        tick(); RegWriteW = 1'b0; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL hazard_after_stall got %b exp 0", stall); n_err++; end
        n_vec++; if (rd1 !== 19'h2A5A5) begin $display("FAIL hazard_after_rd1 got %h exp %h", rd1, 19'h2A5A5); n_err++; end
        n_vec++; if (retire_count !== 16'd3) begin $display("FAIL hazard_retire got %0d exp 3", retire_count); n_err++; end
    endtask

    task automatic test_two_in_flight();
        tick(); idle_inputs(); issue(2'd0);
        tick(); issue(2'd0);
        tick(); idle_inputs(); ra1 = 2'd0; ra_use = 3'b001; settle();
        n_vec++; if (stall !== 1'b1) begin $display("FAIL two_pending got %b exp 1", stall); n_err++; end
        tick(); RegWriteW = 1'b1; r1W_addr = 2'd0; AluOutW = 19'h00111; settle();
        n_vec++; if (stall !== 1'b1) begin $display("FAIL two_first_commit got %b exp 1", stall); n_err++; end
        tick(); AluOutW = 19'h00222; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL two_second_commit got %b exp 0", stall); n_err++; end
        n_vec++; if (rd1 !== 19'h00222) begin $display("FAIL two_second_rd1 got %h exp %h", rd1, 19'h00222); n_err++; end
        tick(); RegWriteW = 1'b0; settle();
        n_vec++; if (retire_count !== 16'd5) begin $display("FAIL two_retire got %0d exp 5", retire_count); n_err++; end
        n_vec++; if (sb_err !== 1'b0) begin $display("FAIL two_sb_err got %b exp 0", sb_err); n_err++; end
    endtask

    task automatic test_simul_incdec();
        tick(); idle_inputs(); issue(2'd2);
        tick(); idle_inputs(); issue(2'd2); RegWriteW = 1'b1; r1W_addr = 2'd2;
        tick(); idle_inputs(); ra1 = 2'd2; ra_use = 3'b001; settle();
        n_vec++; if (stall !== 1'b1) begin $display("FAIL same_reg_pend got %b exp 1", stall); n_err++; end
        // issue r3 while r2 retires: both must apply
        tick(); idle_inputs(); issue(2'd3); RegWriteW = 1'b1; r1W_addr = 2'd2;
        tick(); idle_inputs(); ra1 = 2'd2; ra2 = 2'd3; ra_use = 3'b001; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL diff_reg_dec got %b exp 0", stall); n_err++; end
        ra_use = 3'b010; settle();
        n_vec++; if (stall !== 1'b1) begin $display("FAIL diff_reg_inc got %b exp 1", stall); n_err++; end
        tick(); idle_inputs(); RegWriteW = 1'b1; r1W_addr = 2'd3;
        tick(); idle_inputs(); settle();
        n_vec++; if (retire_count !== 16'd8) begin $display("FAIL simul_retire got %0d exp 8", retire_count); n_err++; end
        n_vec++; if (sb_err !== 1'b0) begin $display("FAIL simul_sb_err got %b exp 0", sb_err); n_err++; end
    endtask

    task automatic test_sb_err();
        for (int i = 0; i < 4; i++) begin
            tick(); idle_inputs(); issue(2'd1);
        end
        tick(); idle_inputs(); settle();
        n_vec++; if (sb_err !== 1'b1) begin $display("FAIL overflow_err got %b exp 1", sb_err); n_err++; end
        // saturated at 3: two commits leave one outstanding
        RegWriteW = 1'b1; r1W_addr = 2'd1; tick(); tick();
        RegWriteW = 1'b0; ra1 = 2'd1; ra_use = 3'b001; settle();
        n_vec++; if (stall !== 1'b1) begin $display("FAIL saturate_pend got %b exp 1", stall); n_err++; end
        RegWriteW = 1'b1; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL saturate_last got %b exp 0", stall); n_err++; end
        tick(); idle_inputs(); tick(); settle();
        n_vec++; if (sb_err !== 1'b1) begin $display("FAIL overflow_sticky got %b exp 1", sb_err); n_err++; end
        rst = 1'b0; ra_use = 3'b001; ra1 = 2'd1; settle();
        n_vec++; if (sb_err !== 1'b0) begin $display("FAIL async_reset_err got %b exp 0", sb_err); n_err++; end
        n_vec++; if (retire_count !== 16'd0) begin $display("FAIL async_reset_retire got %0d exp 0", retire_count); n_err++; end
        n_vec++; if (rd1 !== 19'h0) begin $display("FAIL async_reset_rd1 got %h exp 0", rd1); n_err++; end
        tick(); rst = 1'b1; idle_inputs();
        // underflow: commit with nothing pending
        tick(); RegWriteW = 1'b1; r1W_addr = 2'd0;
        tick(); idle_inputs(); settle();
        n_vec++; if (sb_err !== 1'b1) begin $display("FAIL underflow_err got %b exp 1", sb_err); n_err++; end
        ra1 = 2'd0; ra_use = 3'b001; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL underflow_pend got %b exp 0", stall); n_err++; end
        tick(); tick(); settle();
        n_vec++; if (sb_err !== 1'b1) begin $display("FAIL underflow_sticky got %b exp 1", sb_err); n_err++; end
        rst = 1'b0; tick(); rst = 1'b1; idle_inputs();
    endtask

    task automatic test_wrap();
        tick(); idle_inputs(); issue(2'd0);
        for (int i = 0; i < 65536; i++) begin
            tick(); idle_inputs();
            RegWriteW = 1'b1; r1W_addr = i[1:0] & 2'd1; AluOutW = 19'(i);
            issue((i[1:0] & 2'd1) ^ 2'd1);
            if (i == 65535) begin
                n_vec++; if (retire_count !== 16'hFFFF) begin $display("FAIL wrap_pre got %h exp ffff", retire_count); n_err++; end
            end
        end
        tick(); idle_inputs(); settle();
        n_vec++; if (retire_count !== 16'd0) begin $display("FAIL wrap_count got %h exp 0", retire_count); n_err++; end
        n_vec++; if (sb_err !== 1'b0) begin $display("FAIL wrap_sb_err got %b exp 0", sb_err); n_err++; end
        ra1 = 2'd0; ra2 = 2'd1; ra_use = 3'b001; settle();
        n_vec++; if (stall !== 1'b1) begin $display("FAIL wrap_pend0 got %b exp 1", stall); n_err++; end
        ra_use = 3'b010; settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL wrap_pend1 got %b exp 0", stall); n_err++; end
        n_vec++; if (rd2 !== 19'h0FFFF) begin $display("FAIL wrap_last_data got %h exp %h", rd2, 19'h0FFFF); n_err++; end
    endtask

    initial begin
        test_reset();
        test_mux_bypass();
        test_hazard();
        test_two_in_flight();
        test_simul_incdec();
        test_sb_err();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
